enable_nto1_mux_reg: RTL and testbench
======================================

// Module: enable_nto1_mux_reg
// PURPOSE
//  Parametrised, registered N-to-1 data selector with enable. Generalises the 2:1 enable mux
//  to NUM_CH channels of WIDTH bits, adds valid/ready flow control and a round-robin mode.
//  Sits between several producer channels and a single consumer; one output register stage.
// PARAMETERS
//  WIDTH    8  data bits per channel
//  NUM_CH   4  number of input channels, >=2, need not be a power of 2
//  SEL_W    $clog2(NUM_CH)  select width (derived localparam, not overridable)
// PORTS
//  clk        in   1             rising-edge clock; single clock domain
//  rst_n      in   1             asynchronous, active-low reset
//  en         in   1             block enable; 0 = output forced to zero, no new grants
//  mode       in   1             0 = FIXED (use sel), 1 = RR (round-robin over in_valid)
//  sel        in   SEL_W         channel select, used in FIXED mode only
//  in_data    in   NUM_CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
//  in_valid   in   NUM_CH        per-channel data valid
//  in_ready   out  NUM_CH        per-channel accept; one-hot or zero
//  out_data   out  WIDTH         registered selected data
//  out_valid  out  1             out_data holds a beat
//  out_ready  in   1             consumer accepts beat
//  out_ch     out  SEL_W         channel index of the held beat
// BEHAVIOUR
//  Reset (async assert, sync release): held register empty, out_data=0, out_valid=0, out_ch=0,
//   in_ready=0, RR pointer=0.
//  Handshake: a transfer occurs on a channel when in_valid[c] & in_ready[c] at a clk edge; the
//   output transfer occurs when out_valid & out_ready. Once raised, in_valid must stay high,
//   with stable data, until accepted.
//  Slot free = register empty OR (out_valid & out_ready) in the same cycle (full throughput,
//   1 beat/cycle). Latency: accepted beat appears on out_data/out_valid 1 cycle later.
//  FIXED mode: grant = sel when en & slot free & in_valid[sel]; sel >= NUM_CH -> no grant.
//  RR mode: grant = first c with in_valid[c], searching from pointer upward with wrap at
//   NUM_CH-1 -> 0. After a grant to c, pointer <= (c==NUM_CH-1) ? 0 : c+1. No grant -> pointer holds.
//  in_ready is combinational from en, mode, sel, in_valid, slot free and pointer; at most one bit set.
//  en=0: in_ready=0, and out_data/out_valid/out_ch are forced to 0 combinationally. The held
//   register, its contents and the pointer are preserved, so no beat is lost. out_ready is ignored.
//   On en=1 the held beat reappears in the same cycle.
//  mode or sel change: takes effect on the next grant decision only; the held beat is unaffected.
//   The pointer keeps its value while mode=0.
//  Simultaneous drain + accept: the register is overwritten with the new beat, out_valid stays 1.
//  Reset mid-operation: the held beat is discarded and all state returns to its reset values.
// STRUCTURE
//  Package enable_mux_pkg: MODE_FIXED=1'b0, MODE_RR=1'b1 and the clog2 helper function.
//  Sub-module rr_arbiter_n (NUM_CH): req, ptr -> one-hot gnt and encoded index. It is purely
//   combinational. The pointer register lives in the top module.
//  Top module: grant mux, output register with valid, pointer update, en output gating.
// TESTING
//  1 Reset: rst_n=0 mid-traffic -> out_valid=0, out_data=0, in_ready=0 immediately (async).
//  2 FIXED, sel=2, in_valid=4'b1111, ch2 data=8'hA5, out_ready=1 -> in_ready=4'b0100;
//    out_data=A5, out_ch=2 next cycle; sel=5 with NUM_CH=6 and in_valid[5]=0 -> no grant.
//  3 RR, all valid, out_ready=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3, one per cycle.
//  4 RR wrap: pointer=3, in_valid=4'b0011 -> grant 0, then 1; in_valid=4'b1000 -> grant 3, ptr=0.
//  5 Backpressure: out_ready=0 with a held beat 8'h3C -> in_ready=0 and the beat stays stable;
//    raise out_ready -> 3C drains and a new beat loads in the same cycle.
//  6 en drop while holding 8'h77 -> out_valid=0, out_data=0, no grants; en=1 -> 77 reappears
//    with its original out_ch.

Source files
------------

// File: rtl/enable_mux_pkg.sv
// Shared constants and helpers for the enable N:1 registered mux.
// No logic of its own and no latency; it carries no flow control.
package enable_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Ceiling log2. The result is at least 1 so that a 1-bit select still exists.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin picker: first requester at or above ptr, wrapping at NUM_CH-1.
// Purely combinational (0 cycles); the pointer register is held by the caller.
// No backpressure of its own; the caller qualifies the grant with slot availability.
module rr_arbiter_n
    import enable_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [SEL_W-1:0]  gnt_idx
);

    int   c;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        c       = 0;
        for (int off = 0; off < NUM_CH; off++) begin
            c = int'(ptr) + off;
            if (c >= NUM_CH) c = c - NUM_CH;
            if (!found && req[c]) begin
                found   = 1'b1;
                gnt[c]  = 1'b1;
                gnt_idx = SEL_W'(c);
            end
        end
    end

endmodule

// File: rtl/enable_nto1_mux_reg.sv
// Registered N:1 selector with enable, fixed-select or round-robin grant.
// Latency: an accepted beat appears on out_data/out_valid one cycle later.
// Backpressure: a beat is accepted only when the holding register is empty or draining.
module enable_nto1_mux_reg
    import enable_mux_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_ch
);

    logic              hold_vld;
    logic [WIDTH-1:0]  hold_dat;
    logic [SEL_W-1:0]  hold_ch;
    logic [SEL_W-1:0]  ptr;

    logic [NUM_CH-1:0] rr_gnt;
    logic [SEL_W-1:0]  rr_idx;
    logic [NUM_CH-1:0] fix_gnt;
    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic [WIDTH-1:0]  grant_dat;
    logic              drain;
    logic              slot_free;
    logic              take;

    rr_arbiter_n #(.NUM_CH(NUM_CH)) u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx)
    );

    // While disabled the consumer cannot see the beat, so it cannot drain it either.
    assign drain     = en & hold_vld & out_ready;
    assign slot_free = ~hold_vld | drain;

    always_comb begin
        fix_gnt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            fix_gnt[c] = (int'(sel) == c) & in_valid[c];
        end
    end

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        if (rst_n && en && slot_free) begin
            if (mode == MODE_RR) begin
                grant     = rr_gnt;
                grant_idx = rr_idx;
            end else begin
                grant     = fix_gnt;
                grant_idx = sel;
            end
        end
    end

    always_comb begin
        grant_dat = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant[c]) grant_dat = grant_dat | in_data[c*WIDTH +: WIDTH];
        end
    end

    assign take     = |grant;
    assign in_ready = grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld <= 1'b0;
            hold_dat <= '0;
            hold_ch  <= '0;
        end else if (take) begin
            hold_vld <= 1'b1;
            hold_dat <= grant_dat;
            hold_ch  <= grant_idx;
        end else if (drain) begin
            hold_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (take && mode == MODE_RR) begin
            ptr <= (rr_idx == SEL_W'(NUM_CH - 1)) ? '0 : rr_idx + SEL_W'(1);
        end
    end

    assign out_valid = en & hold_vld;
    assign out_data  = out_valid ? hold_dat : '0;
    assign out_ch    = out_valid ? hold_ch  : '0;

endmodule

// File: tb/tb_enable_nto1_mux_reg.sv
// Directed bench for enable_nto1_mux_reg: a 4-channel instance plus a 6-channel one
// for non-power-of-two select range.
module tb_enable_nto1_mux_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, mode, out_ready;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid, in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [1:0]  out_ch;

    logic        en6, mode6, out_ready6;
    logic [2:0]  sel6;
    logic [47:0] in_data6;
    logic [5:0]  in_valid6, in_ready6;
    logic [7:0]  out_data6;
    logic        out_valid6;
    logic [2:0]  out_ch6;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    enable_nto1_mux_reg #(.WIDTH(8), .NUM_CH(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
    );

    enable_nto1_mux_reg #(.WIDTH(8), .NUM_CH(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .en(en6), .mode(mode6), .sel(sel6),
        .in_data(in_data6), .in_valid(in_valid6), .in_ready(in_ready6),
        .out_data(out_data6), .out_valid(out_valid6), .out_ready(out_ready6), .out_ch(out_ch6)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; mode = 1'b0; sel = 2'd0; out_ready = 1'b0;
        in_data = 32'h000000C3; in_valid = 4'b0001;
        #2;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0 || in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_init: valid=%b data=%h ch=%0d rdy=%b, want 0/00/0/0000",
                     out_valid, out_data, out_ch, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 8'hC3) begin
            n_fail++;
            $display("FAIL reset_load: valid=%b data=%h, want 1/c3", out_valid, out_data);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_async: valid=%b data=%h rdy=%b, want 0/00/0000",
                     out_valid, out_data, in_ready);
        end
        in_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_discard: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_fixed();
        en = 1'b1; mode = 1'b0; sel = 2'd2; out_ready = 1'b1;
        in_data = 32'h44A52211; in_valid = 4'b1111;
        #1;
        n_tests++;
        if (in_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL fixed_rdy: in_ready=%b, want 0100", in_ready);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
            n_fail++;
            $display("FAIL fixed_out: valid=%b data=%h ch=%0d, want 1/a5/2", out_valid, out_data, out_ch);
        end
        sel = 2'd1;
        #1;
        n_tests++;
        if (in_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL fixed_sel1_rdy: in_ready=%b, want 0010", in_ready);
        end
        tick();
        n_tests++;
        if (out_data !== 8'h22 || out_ch !== 2'd1) begin
            n_fail++;
            $display("FAIL fixed_sel1_out: data=%h ch=%0d, want 22/1", out_data, out_ch);
        end
        in_valid = 4'b0000;
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fixed_drain: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_fixed6();
        en6 = 1'b1; mode6 = 1'b0; out_ready6 = 1'b1; sel6 = 3'd5;
        in_data6 = 48'h6655_4433_2211; in_valid6 = 6'b011111;
        #1;
        n_tests++;
        if (in_ready6 !== 6'b000000) begin
            n_fail++;
            $display("FAIL fixed6_sel5_idle: in_ready=%b, want 000000", in_ready6);
        end
        tick();
        n_tests++;
        if (out_valid6 !== 1'b0) begin
            n_fail++;
            $display("FAIL fixed6_nogrant: valid=%b, want 0", out_valid6);
        end
        sel6 = 3'd7; in_valid6 = 6'b111111;
        #1;
        n_tests++;
        if (in_ready6 !== 6'b000000) begin
            n_fail++;
            $display("FAIL fixed6_sel_oob: in_ready=%b, want 000000", in_ready6);
        end
        sel6 = 3'd5; in_valid6 = 6'b100000;
        #1;
        n_tests++;
        if (in_ready6 !== 6'b100000) begin
            n_fail++;
            $display("FAIL fixed6_sel5_rdy: in_ready=%b, want 100000", in_ready6);
        end
        tick();
        in_valid6 = 6'b000000;
        n_tests++;
        if (out_valid6 !== 1'b1 || out_data6 !== 8'h66 || out_ch6 !== 3'd5) begin
            n_fail++;
            $display("FAIL fixed6_out: valid=%b data=%h ch=%0d, want 1/66/5", out_valid6, out_data6, out_ch6);
        end
        tick();
    endtask

    task automatic test_rr();
        logic [31:0] d;
        logic [7:0]  exp_d;
        logic [1:0]  exp_ch;
        d = 32'hD4C3B2A1;
        mode = 1'b1; out_ready = 1'b1; in_data = d; in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            exp_ch = 2'(i % 4);
            exp_d  = d[exp_ch*8 +: 8];
            #1;
            n_tests++;
            if (in_ready !== (4'b0001 << exp_ch)) begin
                n_fail++;
                $display("FAIL rr_rdy[%0d]: in_ready=%b, want ch %0d", i, in_ready, exp_ch);
            end
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || out_ch !== exp_ch || out_data !== exp_d) begin
                n_fail++;
                $display("FAIL rr_out[%0d]: valid=%b ch=%0d data=%h, want 1/%0d/%h",
                         i, out_valid, out_ch, out_data, exp_ch, exp_d);
            end
        end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_rr_wrap();
        mode = 1'b1; out_ready = 1'b1; in_data = 32'hD4C3B2A1;
        in_valid = 4'b0100;
        tick();
        n_tests++;
        if (out_ch !== 2'd2) begin
            n_fail++;
            $display("FAIL rr_wrap_setup: ch=%0d, want 2", out_ch);
        end
        in_valid = 4'b0011;
        #1;
        n_tests++;
        if (in_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL rr_wrap_g0: in_ready=%b, want 0001", in_ready);
        end
        tick();
        n_tests++;
        if (out_ch !== 2'd0 || in_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL rr_wrap_g1: ch=%0d rdy=%b, want 0/0010", out_ch, in_ready);
        end
        tick();
        n_tests++;
        if (out_ch !== 2'd1 || out_data !== 8'hB2) begin
            n_fail++;
            $display("FAIL rr_wrap_out1: ch=%0d data=%h, want 1/b2", out_ch, out_data);
        end
        in_valid = 4'b1000;
        #1;
        n_tests++;
        if (in_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL rr_wrap_g3: in_ready=%b, want 1000", in_ready);
        end
        tick();
        in_valid = 4'b1111;
        #1;
        n_tests++;
        if (out_ch !== 2'd3 || in_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL rr_wrap_ptr0: ch=%0d rdy=%b, want 3/0001", out_ch, in_ready);
        end
        tick();
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_backpressure();
        mode = 1'b0; sel = 2'd0; out_ready = 1'b0;
        in_data = 32'h0000003C; in_valid = 4'b0001;
        tick();
        in_data = 32'h0000005A;
        #1;
        n_tests++;
        if (out_data !== 8'h3C || out_valid !== 1'b1 || in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_hold: data=%h valid=%b rdy=%b, want 3c/1/0000", out_data, out_valid, in_ready);
        end
        tick();
        tick();
        n_tests++;
        if (out_data !== 8'h3C || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_stable: data=%h valid=%b, want 3c/1", out_data, out_valid);
        end
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL bp_release_rdy: in_ready=%b, want 0001", in_ready);
        end
        tick();
        in_valid = 4'b0000;
        n_tests++;
        if (out_data !== 8'h5A || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_drain_load: data=%h valid=%b, want 5a/1", out_data, out_valid);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_empty: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_enable();
        mode = 1'b0; sel = 2'd1; out_ready = 1'b0;
        in_data = 32'h00007700; in_valid = 4'b0010;
        tick();
        in_valid = 4'b0000;
        en = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
            n_fail++;
            $display("FAIL en_off_out: valid=%b data=%h ch=%0d, want 0/00/0", out_valid, out_data, out_ch);
        end
        in_data = 32'h00008800; in_valid = 4'b0010; out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL en_off_rdy: in_ready=%b, want 0000", in_ready);
        end
        tick();
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL en_off_hold: valid=%b rdy=%b, want 0/0000", out_valid, in_ready);
        end
        in_valid = 4'b0000;
        en = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 8'h77 || out_ch !== 2'd1) begin
            n_fail++;
            $display("FAIL en_restore: valid=%b data=%h ch=%0d, want 1/77/1", out_valid, out_data, out_ch);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL en_drain: valid=%b, want 0", out_valid);
        end
    endtask

    initial begin
        en6 = 1'b0; mode6 = 1'b0; sel6 = 3'd0; out_ready6 = 1'b0;
        in_data6 = '0; in_valid6 = '0;
        test_reset();
        test_fixed();
        test_fixed6();
        test_rr();
        test_rr_wrap();
        test_backpressure();
        test_enable();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
